// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the fetch-stage PC sequencer slice.
//   state_t     : sequencer FSM states (RUN, BUBBLE)
//   ADDR_W      : fetch address width
//   REDIR_CNT_W : width of the accepted-redirect counter
//   PC_STEP     : sequential fetch increment (one 32-bit instruction)
// ---------------------------------------------------------------------------
package if_pkg;

  localparam int ADDR_W      = 32;
  localparam int REDIR_CNT_W = 16;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

endpackage

// File: rtl/if_pc_adder.sv
// ---------------------------------------------------------------------------
// if_pc_adder
// Sequential-fetch incrementer: pcPlus = pcIn + PC_STEP, wrapping mod 2^32.
// Ports:
//   pcIn   in  ADDR_W  current fetch address
//   pcPlus out ADDR_W  next sequential fetch address
// ---------------------------------------------------------------------------
module if_pc_adder
  import if_pkg::*;
(
  input  logic [ADDR_W-1:0] pcIn,
  output logic [ADDR_W-1:0] pcPlus
);

  // Plain modular add; carry out of bit 31 is discarded so 0xFFFF_FFFC
  // rolls over to 0.
  assign pcPlus = pcIn + PC_STEP;

endmodule

// File: rtl/if_pc_sequencer.sv
// ---------------------------------------------------------------------------
// if_pc_sequencer
// Fetch-stage program-counter sequencer. Holds the fetch PC, steps it by 4,
// honours hazard stalls and takes EX-stage branch redirects with a
// configurable bubble (FLUSH_CYCLES) during which IF/ID is squashed.
//
// Parameters:
//   RESET_PC      fetch address after reset
//   FLUSH_CYCLES  redirect penalty in cycles (1..15)
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hazard-unit PC hold (ignored in BUBBLE)
//   branchTaken    in   1   EX-stage branch resolved taken
//   branchTarget   in   32  redirect target from the EX branch adder
//   pc             out  32  registered instruction-memory fetch address
//   PostPc         out  32  pc + 4 (combinational) to IF/ID
//   fetchValid     out  1   instruction at pc is architecturally valid
//   flushIFID      out  1   squash IF/ID contents this cycle
//   redirectCount  out  16  accepted-redirect counter (wraps)
//   misaligned     out  1   misaligned-target pulse
//
// Build option:
//   PC_ALIGN_CHECK_EN  when defined, misaligned redirect targets are forced
//                      to word alignment and flagged on 'misaligned' for one
//                      cycle; when undefined the target loads unmodified and
//                      'misaligned' is tied low.
// ---------------------------------------------------------------------------
module if_pc_sequencer
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned       FLUSH_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branchTaken,
  input  logic [ADDR_W-1:0]      branchTarget,
  output logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      PostPc,
  output logic                   fetchValid,
  output logic                   flushIFID,
  output logic [REDIR_CNT_W-1:0] redirectCount,
  output logic                   misaligned
);

  // The bubble counter is reloaded with FLUSH_CYCLES-1 so that a value of
  // zero means "this is the last squashed cycle".
  localparam logic [3:0] BUBBLE_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t                 state, stateNext;
  logic [3:0]             bubbleCnt, bubbleCntNext;
  logic [ADDR_W-1:0]      pcNext;
  logic                   fetchValidNext;
  logic                   flushNext;
  logic [REDIR_CNT_W-1:0] redirectCountNext;
  logic [ADDR_W-1:0]      loadTarget;

  // Sequential incrementer shared by PostPc and the next-pc mux.
  if_pc_adder u_adder (
    .pcIn   (pc),
    .pcPlus (PostPc)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misalignedNext;

  // Misaligned targets are snapped down to the enclosing word so fetch
  // never issues an unaligned address.
  assign loadTarget = {branchTarget[ADDR_W-1:2], 2'b00};
`else
  assign loadTarget = branchTarget;
  assign misaligned = 1'b0;
`endif

  // Next-state and next-output logic. A taken branch is checked before
  // anything else so it wins over stall and over an in-progress bubble.
  // In RUN, fetchValid==0 only occurs on the first edge after reset; that
  // edge validates RESET_PC instead of stepping past it.
  always_comb begin
    stateNext         = state;
    pcNext            = pc;
    fetchValidNext    = fetchValid;
    flushNext         = flushIFID;
    bubbleCntNext     = bubbleCnt;
    redirectCountNext = redirectCount;
`ifdef PC_ALIGN_CHECK_EN
    misalignedNext    = 1'b0;
`endif

    if (branchTaken) begin
      stateNext         = BUBBLE;
      pcNext            = loadTarget;
      bubbleCntNext     = BUBBLE_RELOAD;
      fetchValidNext    = 1'b0;
      flushNext         = 1'b1;
      redirectCountNext = redirectCount + 16'd1;
`ifdef PC_ALIGN_CHECK_EN
      misalignedNext    = |branchTarget[1:0];
`endif
    end else begin
      case (state)
        RUN: begin
          fetchValidNext = 1'b1;
          flushNext      = 1'b0;
          if (!stall && fetchValid) begin
            pcNext = PostPc;
          end
        end
        BUBBLE: begin
          if (bubbleCnt == 4'd0) begin
            stateNext      = RUN;
            fetchValidNext = 1'b1;
            flushNext      = 1'b0;
          end else begin
            bubbleCntNext  = bubbleCnt - 4'd1;
            fetchValidNext = 1'b0;
            flushNext      = 1'b1;
          end
        end
      endcase
    end
  end

  // State register. Reset is asynchronous so a reset arriving mid-bubble
  // takes effect immediately rather than at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc            <= RESET_PC;
      fetchValid    <= 1'b0;
      flushIFID     <= 1'b0;
      bubbleCnt     <= 4'd0;
      redirectCount <= '0;
    end else begin
      state         <= stateNext;
      pc            <= pcNext;
      fetchValid    <= fetchValidNext;
      flushIFID     <= flushNext;
      bubbleCnt     <= bubbleCntNext;
      redirectCount <= redirectCountNext;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned flag is registered alongside the pc load so it lines up with
  // the corrected address on the fetch bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= misalignedNext;
    end
  end
`endif

endmodule

// File: tb/tb_if_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_if_pc_sequencer
// Directed bench for if_pc_sequencer. Two instances share clock and reset:
// dut1 uses FLUSH_CYCLES=1, dut3 uses FLUSH_CYCLES=3.
// ---------------------------------------------------------------------------
module tb_if_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        stall1, bt1;
  logic [31:0] tgt1;
  logic [31:0] pc1, post1;
  logic        fv1, fl1, mis1;
  logic [15:0] rc1;

  logic        stall3, bt3;
  logic [31:0] tgt3;
  logic [31:0] pc3, post3;
  logic        fv3, fl3, mis3;
  logic [15:0] rc3;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  if_pc_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall1),
    .branchTaken   (bt1),
    .branchTarget  (tgt1),
    .pc            (pc1),
    .PostPc        (post1),
    .fetchValid    (fv1),
    .flushIFID     (fl1),
    .redirectCount (rc1),
    .misaligned    (mis1)
  );

  if_pc_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(3)) dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall3),
    .branchTaken   (bt3),
    .branchTarget  (tgt3),
    .pc            (pc3),
    .PostPc        (post3),
    .fetchValid    (fv3),
    .flushIFID     (fl3),
    .redirectCount (rc3),
    .misaligned    (mis3)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    stall1 = 1'b0; bt1 = 1'b0; tgt1 = 32'h0;
    stall3 = 1'b0; bt3 = 1'b0; tgt3 = 32'h0;
    #12;
    testsRun++;
    if (pc1 !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc1, 32'h0);
    end
    testsRun++;
    if (post1 !== 32'h4) begin
      testsFailed++; $display("[TB] FAIL reset_postpc got=%h exp=%h", post1, 32'h4);
    end
    testsRun++;
    if ({fv1, fl1, mis1} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags got=%b exp=000", {fv1, fl1, mis1});
    end
    testsRun++;
    if (rc1 !== 16'd0) begin
      testsFailed++; $display("[TB] FAIL reset_count got=%0d exp=0", rc1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    testsRun++;
    if (pc1 !== 32'h0 || fv1 !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL first_edge got pc=%h fv=%b exp pc=0 fv=1", pc1, fv1);
    end
    tick();
    testsRun++;
    if (pc1 !== 32'h4) begin
      testsFailed++; $display("[TB] FAIL second_edge got=%h exp=%h", pc1, 32'h4);
    end
    tick();
    testsRun++;
    if (pc1 !== 32'h8) begin
      testsFailed++; $display("[TB] FAIL third_edge got=%h exp=%h", pc1, 32'h8);
    end
  endtask

  task automatic test_stall();
    stall1 = 1'b1;
    tick();
    tick();
    testsRun++;
    if (pc1 !== 32'h8 || fv1 !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL stall_hold got pc=%h fv=%b exp pc=8 fv=1", pc1, fv1);
    end
    stall1 = 1'b0;
    tick();
    testsRun++;
    if (pc1 !== 32'hC) begin
      testsFailed++; $display("[TB] FAIL stall_release got=%h exp=%h", pc1, 32'hC);
    end
    tick();
  endtask

  task automatic test_branch();
    testsRun++;
    if (pc1 !== 32'h10) begin
      testsFailed++; $display("[TB] FAIL pre_branch_pc got=%h exp=%h", pc1, 32'h10);
    end
    bt1 = 1'b1; tgt1 = 32'h100;
    tick();
    bt1 = 1'b0;
    testsRun++;
    if (pc1 !== 32'h100 || fv1 !== 1'b0 || fl1 !== 1'b1 || rc1 !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL branch_c1 got pc=%h fv=%b fl=%b rc=%0d exp pc=100 fv=0 fl=1 rc=1",
               pc1, fv1, fl1, rc1);
    end
    tick();
    testsRun++;
    if (pc1 !== 32'h100 || fv1 !== 1'b1 || fl1 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL branch_c2 got pc=%h fv=%b fl=%b exp pc=100 fv=1 fl=0", pc1, fv1, fl1);
    end
    tick();
    testsRun++;
    if (pc1 !== 32'h104) begin
      testsFailed++; $display("[TB] FAIL branch_c3 got=%h exp=%h", pc1, 32'h104);
    end
  endtask

  task automatic test_branch_vs_stall();
    bt1 = 1'b1; stall1 = 1'b1; tgt1 = 32'h40;
    tick();
    bt1 = 1'b0; stall1 = 1'b0;
    testsRun++;
    if (pc1 !== 32'h40 || rc1 !== 16'd2 || fl1 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL branch_over_stall got pc=%h rc=%0d fl=%b exp pc=40 rc=2 fl=1",
               pc1, rc1, fl1);
    end
    tick();
    tick();
    testsRun++;
    if (pc1 !== 32'h44) begin
      testsFailed++; $display("[TB] FAIL branch_over_stall_next got=%h exp=%h", pc1, 32'h44);
    end
  endtask

  task automatic test_wrap_align();
    bt1 = 1'b1; tgt1 = 32'hFFFF_FFFC;
    tick();
    bt1 = 1'b0;
    testsRun++;
    if (pc1 !== 32'hFFFF_FFFC || post1 !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_postpc got pc=%h post=%h exp pc=fffffffc post=0", pc1, post1);
    end
    tick();
    tick();
    testsRun++;
    if (pc1 !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL wrap_pc got=%h exp=%h", pc1, 32'h0);
    end
    bt1 = 1'b1; tgt1 = 32'h103;
    tick();
    bt1 = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    testsRun++;
    if (pc1 !== 32'h100 || mis1 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL align_load got pc=%h mis=%b exp pc=100 mis=1", pc1, mis1);
    end
`else
    testsRun++;
    if (pc1 !== 32'h103 || mis1 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL align_load got pc=%h mis=%b exp pc=103 mis=0", pc1, mis1);
    end
`endif
    tick();
    testsRun++;
    if (mis1 !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL align_pulse_end got=%b exp=0", mis1);
    end
  endtask

  task automatic test_back_to_back();
    bt3 = 1'b1; tgt3 = 32'h80;
    tick();
    bt3 = 1'b0;
    testsRun++;
    if (pc3 !== 32'h80 || fl3 !== 1'b1 || rc3 !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first got pc=%h fl=%b rc=%0d exp pc=80 fl=1 rc=1", pc3, fl3, rc3);
    end
    stall3 = 1'b1;
    tick();
    testsRun++;
    if (fl3 !== 1'b1 || fv3 !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL b2b_bubble2 got fl=%b fv=%b exp fl=1 fv=0", fl3, fv3);
    end
    bt3 = 1'b1; tgt3 = 32'h200;
    tick();
    bt3 = 1'b0;
    testsRun++;
    if (pc3 !== 32'h200 || rc3 !== 16'd2 || fl3 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_redirect got pc=%h rc=%0d fl=%b exp pc=200 rc=2 fl=1", pc3, rc3, fl3);
    end
    tick();
    testsRun++;
    if (fl3 !== 1'b1 || fv3 !== 1'b0 || pc3 !== 32'h200) begin
      testsFailed++;
      $display("[TB] FAIL b2b_flush2 got fl=%b fv=%b pc=%h exp fl=1 fv=0 pc=200", fl3, fv3, pc3);
    end
    stall3 = 1'b0;
    tick();
    testsRun++;
    if (fl3 !== 1'b1 || fv3 !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL b2b_flush3 got fl=%b fv=%b exp fl=1 fv=0", fl3, fv3);
    end
    tick();
    testsRun++;
    if (pc3 !== 32'h200 || fv3 !== 1'b1 || fl3 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_exit got pc=%h fv=%b fl=%b exp pc=200 fv=1 fl=0", pc3, fv3, fl3);
    end
    tick();
    testsRun++;
    if (pc3 !== 32'h204) begin
      testsFailed++; $display("[TB] FAIL b2b_next got=%h exp=%h", pc3, 32'h204);
    end
  endtask

  task automatic test_reset_mid_bubble();
    bt3 = 1'b1; tgt3 = 32'h300;
    tick();
    bt3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (pc3 !== 32'h0 || fl3 !== 1'b0 || fv3 !== 1'b0 || rc3 !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_bubble got pc=%h fl=%b fv=%b rc=%0d exp pc=0 fl=0 fv=0 rc=0",
               pc3, fl3, fv3, rc3);
    end
    #1;
    rst_n = 1'b1;
    tick();
    testsRun++;
    if (pc3 !== 32'h0 || fv3 !== 1'b1 || fl3 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_bubble_after got pc=%h fv=%b fl=%b exp pc=0 fv=1 fl=0",
               pc3, fv3, fl3);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_branch_vs_stall();
    test_wrap_align();
    test_back_to_back();
    test_reset_mid_bubble();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/if_pc_sequencer.md
# if_pc_sequencer

Fetch-stage program-counter sequencer for the 5-stage pipeline. It holds the fetch PC, advances it by 4, and honours hazard-unit stalls. It accepts the taken-branch redirect resolved in EX, whose target is PostPc + shifted offset. It produces PostPc for IF/ID, and therefore both produces the EX branch adder's base operand and consumes its result.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- FLUSH_CYCLES, 1: redirect penalty in cycles (1..15).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit PC hold.
- branchTaken  in  1  EX-stage branch resolved taken.
- branchTarget  in  32  target from the EX branch adder.
- pc  out  32  registered instruction-memory fetch address.
- PostPc  out  32  pc + 4, combinational, to IF/ID.
- fetchValid  out  1  instruction at pc is architecturally valid.
- flushIFID  out  1  squash IF/ID contents this cycle.
- redirectCount  out  16  accepted-redirect counter.
- misaligned  out  1  misaligned-target pulse (see Configuration).

## Operation
- Reset values (rst_n=0, asynchronous):
  - pc=RESET_PC, state=RUN, fetchValid=0, flushIFID=0.
  - bubble counter=0, redirectCount=0, misaligned=0.
- PostPc = pc + 32'd4, modulo 2^32. 0xFFFF_FFFC gives 0x0000_0000.
- States: RUN, BUBBLE.
- RUN, per edge, in priority order:
  1. branchTaken=1:
     - pc<=branchTarget, state<=BUBBLE, bubble counter<=FLUSH_CYCLES-1.
     - fetchValid<=0, flushIFID<=1, redirectCount<=redirectCount+1 (wraps at 16 bits).
  2. stall=1: pc, fetchValid hold; fetchValid becomes 1 if it was 0 from reset.
  3. Otherwise: pc<=pc+4, fetchValid<=1.
- BUBBLE, per edge:
  - branchTaken=1: redirect exactly as in RUN (new target, counter reloaded, redirectCount incremented).
  - Else if counter=0: state<=RUN, fetchValid<=1, flushIFID<=0, pc holds. The first valid fetch is the target itself.
  - Else: counter decrements, pc holds, fetchValid=0, flushIFID=1.
  - stall is ignored in BUBBLE: squashed instructions carry no hazard.
- branchTaken beats stall in every state; a resolved branch is never dropped.
- The first edge after rst_n rises leaves pc=RESET_PC with fetchValid<=1. The first increment occurs on the second edge.

## Timing
- Redirect latency: target appears on pc one cycle after the sampling edge.
- Redirect penalty: fetchValid=0 and flushIFID=1 for exactly FLUSH_CYCLES cycles. Then the target is fetched with fetchValid=1, and target+4 follows one cycle later.
- Stall: zero-latency hold at the sampling edge.
- Reset asserted mid-BUBBLE aborts the bubble immediately; all outputs take their reset values asynchronously.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Accepted redirect with branchTarget[1:0]≠0: pc loads {branchTarget[31:2],2'b00}.
  - misaligned pulses high for one cycle, registered alongside the pc update.
  - Redirect, bubble and count behave as normal.
- PC_ALIGN_CHECK_EN undefined:
  - branchTarget loads unmodified.
  - misaligned is tied to 0.

## Structure
- Shared package if_pkg:
  - state typedef {RUN, BUBBLE}.
  - PC_STEP=32'd4, ADDR_W=32, REDIR_CNT_W=16.
- One natural sub-module, if_pc_adder: 32-bit pc + PC_STEP, feeding PostPc and the next-pc mux.
- FSM, bubble counter and redirect counter stay in the top module.

## Test plan
- Reset, RESET_PC=0:
  - During reset: pc=0, PostPc=4, fetchValid=0, redirectCount=0.
  - After release, edge 1 gives pc=0 with fetchValid=1; edge 3 gives pc=8.
- Stall at pc=8 held for 2 cycles: pc stays 8 and fetchValid stays 1. The next free edge gives pc=12.
- branchTaken with target 0x100 at pc=0x10, FLUSH_CYCLES=1:
  - Cycle +1: pc=0x100, fetchValid=0, flushIFID=1, redirectCount=1.
  - Cycle +2: pc=0x100, fetchValid=1.
  - Cycle +3: pc=0x104.
- branchTaken and stall in the same cycle, target 0x40: redirect taken, pc=0x40, redirectCount incremented.
- FLUSH_CYCLES=3, second branchTaken to 0x200 during the bubble's 2nd cycle:
  - pc=0x200 and the bubble restarts.
  - flushIFID is asserted for 3 further cycles; redirectCount=2.
- Wrap and alignment:
  - pc=0xFFFF_FFFC gives PostPc=0.
  - With PC_ALIGN_CHECK_EN, target 0x103 gives pc=0x100 and a one-cycle misaligned pulse.
  - Without the macro, pc=0x103 and misaligned=0.
